dmem_mmio_bridge: RTL and testbench
===================================

// Module: dmem_mmio_bridge
// PURPOSE
//   Sits between the pipeline's data port (MemWrite_out/DataAdr_out/WriteData_out/ReadData) and data RAM.
//   Passes RAM accesses through unchanged; decodes an MMIO window holding a byte TX FIFO, status, a 64-bit
//   cycle counter and a TOHOST exit register. The pipeline never stalls: all MMIO accesses complete in one cycle.
// PARAMETERS
//   MMIO_BASE   32'hFFFF_0000  base of 256-byte MMIO window (addr[31:8]==MMIO_BASE[31:8])
//   FIFO_DEPTH  8              TX FIFO entries, power of two, >=2
// PORTS
//   clk         in   1   clock, all state updates on posedge
//   reset       in   1   asynchronous, active-high; clears all state
//   MemWrite    in   1   core store strobe
//   DataAdr     in   32  core data address (byte address)
//   WriteData   in   32  core store data
//   ReadData    out  32  load data to core (combinational)
//   ram_we      out  1   RAM write enable = MemWrite & ~mmio_hit
//   ram_adr     out  32  = DataAdr
//   ram_wdata   out  32  = WriteData
//   ram_rdata   in   32  RAM read data (combinational RAM)
//   tx_valid    out  1   FIFO head valid (= ~empty)
//   tx_data     out  8   FIFO head byte
//   tx_ready    in   1   sink accepts head this cycle
//   done        out  1   sticky: TOHOST written
//   exit_code   out  32  value of first TOHOST write
// BEHAVIOUR
//   Reset: FIFO empty, count=0, overflow=0, cycle=0, done=0, exit_code=0; tx_valid=0, tx_data=0.
//   Decode (offset = DataAdr[7:0], word aligned; DataAdr[1:0] ignored):
//     0x00 TXDATA  W: push WriteData[7:0]; R: 0
//     0x04 STATUS  R: {16'b0, overflow, full, empty, 5'b0, count[7:0]}  (count = entries, 0..FIFO_DEPTH)
//     0x08 CYC_LO  R: cycle[31:0]       0x0C CYC_HI R: cycle[63:32]
//     0x10 TOHOST  W: if !done -> done<=1, exit_code<=WriteData; R: exit_code
//     0x14 CLROVF  W: overflow<=0 (any data); R: 0
//     other offsets: R 0, W ignored. Writes to read-only regs ignored.
//   ReadData = mmio_hit ? mmio_rdata : ram_rdata, zero latency; reads have no side effects.
//   Writes take effect at the posedge where MemWrite=1; values visible to reads the following cycle.
//   FIFO: circular, rd/wr pointers wrap modulo FIFO_DEPTH; tx_data = mem[rd_ptr], registered storage.
//     pop  = tx_valid & tx_ready;  push = MemWrite & hit & offset==0x00.
//     push & !full -> enqueue. push & full & !pop -> byte dropped, overflow<=1 (sticky until CLROVF/reset).
//     push & full & pop  -> both occur, count unchanged, no overflow.
//     push & empty -> byte visible on tx_data/tx_valid next cycle (no fall-through).
//     CLROVF same cycle as an overflowing push: overflow ends 1 (set wins).
//   tx_valid/tx_data stable while tx_valid & ~tx_ready (AXI-style hold).
//   Cycle counter: +1 every cycle while done=0, 64-bit wrap to 0; freezes once done=1.
//   done/exit_code: first TOHOST write wins; later writes ignored until reset.
//   Reset mid-operation (async): FIFO contents discarded, tx_valid drops immediately.
// TESTING
//   1. RAM store 0xDEADBEEF @0x100 then load @0x100 -> ram_we pulses, ReadData=0xDEADBEEF; no FIFO change.
//   2. Push 'H','i' (0x48,0x69) with tx_ready=0 -> STATUS count=2, empty=0; raise tx_ready -> 0x48 then 0x69, then tx_valid=0.
//   3. Push 9 bytes with tx_ready=0 -> count=8, full=1, overflow=1, 9th byte lost; CLROVF -> overflow=0.
//   4. Full FIFO, push 0xAA and pop same cycle -> count stays 8, overflow=0, 0xAA drains last.
//   5. Write TOHOST 0x1, then 0x5 -> done=1, exit_code=1; CYC_LO stops incrementing after done.
//   6. Assert reset with 3 bytes queued -> tx_valid=0 immediately, count=0, CYC_LO=0 after release.

Source files
------------

// File: rtl/dmem_mmio_bridge.sv
// Data-port bridge between the pipeline and data RAM. Loads and stores pass straight through
// to RAM, except for a 256-byte MMIO window with a TX byte FIFO, status, cycle counter and TOHOST.
module dmem_mmio_bridge #(
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ram_we,
  output logic [31:0] ram_adr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic [31:0] exit_code
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [5:0] REG_TXDATA = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_CYC_LO = 6'h02;
  localparam logic [5:0] REG_CYC_HI = 6'h03;
  localparam logic [5:0] REG_TOHOST = 6'h04;
  localparam logic [5:0] REG_CLROVF = 6'h05;

  logic          mmio_hit;
  logic [5:0]    word_sel;
  logic [31:0]   mmio_rdata;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [63:0]   cycle;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          enq;
  logic          ovf_set;
  logic          ovf_clr;
  logic          tohost_wr;
  logic [7:0]    status_count;

  assign mmio_hit  = (DataAdr[31:8] == MMIO_BASE[31:8]);
  assign word_sel  = DataAdr[7:2];

  assign ram_we    = MemWrite & ~mmio_hit;
  assign ram_adr   = DataAdr;
  assign ram_wdata = WriteData;

  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign status_count = 8'(count);

  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[rd_ptr];

  // A push into a full FIFO still succeeds if the head leaves in the same cycle.
  assign pop       = tx_valid & tx_ready;
  assign push      = MemWrite & mmio_hit & (word_sel == REG_TXDATA);
  assign enq       = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;
  assign ovf_clr   = MemWrite & mmio_hit & (word_sel == REG_CLROVF);
  assign tohost_wr = MemWrite & mmio_hit & (word_sel == REG_TOHOST);

  always_comb begin
    mmio_rdata = 32'h0;
    case (word_sel)
      REG_STATUS: mmio_rdata = {16'h0, overflow, full, empty, 5'b0, status_count};
      REG_CYC_LO: mmio_rdata = cycle[31:0];
      REG_CYC_HI: mmio_rdata = cycle[63:32];
      REG_TOHOST: mmio_rdata = exit_code;
      default:    mmio_rdata = 32'h0;
    endcase
  end

  assign ReadData = mmio_hit ? mmio_rdata : ram_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'h0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        fifo_mem[wr_ptr] <= WriteData[7:0];
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Setting overflow takes priority over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      done      <= 1'b0;
      exit_code <= 32'h0;
      cycle     <= 64'h0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (tohost_wr && !done) begin
        done      <= 1'b1;
        exit_code <= WriteData;
      end
      if (!done) cycle <= cycle + 64'd1;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed bench for dmem_mmio_bridge: RAM pass-through, TX FIFO fill/drain/overflow,
// TOHOST exit handling, cycle counter freeze and asynchronous reset.
module tb_dmem_mmio_bridge;

  localparam logic [31:0] A_TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC_LO = 32'hFFFF_0008;
  localparam logic [31:0] A_CYC_HI = 32'hFFFF_000C;
  localparam logic [31:0] A_TOHOST = 32'hFFFF_0010;
  localparam logic [31:0] A_CLROVF = 32'hFFFF_0014;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ram_we;
  logic [31:0] ram_adr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        done;
  logic [31:0] exit_code;

  int checks;
  int errors;

  logic [63:0] model_cycle;
  logic        model_done;

  dmem_mmio_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .ram_we    (ram_we),
    .ram_adr   (ram_adr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .done      (done),
    .exit_code (exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter: counts every posedge until the first TOHOST store has landed.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_cycle <= 64'h0;
      model_done  <= 1'b0;
    end else begin
      if (!model_done) model_cycle <= model_cycle + 64'd1;
      if (MemWrite && DataAdr == A_TOHOST) model_done <= 1'b1;
    end
  end

  // Drives one cycle of inputs in the low phase; the DUT captures them on the next posedge.
  task automatic applyStimulus(input logic we, input logic [31:0] adr,
                               input logic [31:0] wd, input logic rdy);
    @(negedge clk);
    MemWrite  = we;
    DataAdr   = adr;
    WriteData = wd;
    tx_ready  = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = 32'h0;
    WriteData = 32'h0;
    tx_ready  = 1'b0;
    ram_rdata = 32'hDEAD_BEEF;

    // Reset state
    @(negedge clk);
    DataAdr = A_STATUS;
    #1;
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_exit_code", exit_code, 32'h0);
    checkOutput("rst_status", ReadData, 32'h0000_2000);
    DataAdr = A_CYC_LO;
    #1;
    checkOutput("rst_cyc_lo", ReadData, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 1. RAM pass-through
    applyStimulus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    checkOutput("ram_we_store", 32'(ram_we), 32'h1);
    checkOutput("ram_adr", ram_adr, 32'h0000_0100);
    checkOutput("ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, 1'b0);
    checkOutput("ram_we_load", 32'(ram_we), 32'h0);
    checkOutput("ram_load", ReadData, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'hFFFE_0004, 32'h0, 1'b0);
    checkOutput("near_miss_is_ram", ReadData, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'hFFFF_0020, 32'h0, 1'b0);
    checkOutput("unmapped_reads_0", ReadData, 32'h0);
    applyStimulus(1'b0, A_STATUS, 32'h0, 1'b0);
    checkOutput("no_fifo_change", ReadData, 32'h0000_2000);

    // 2. Push 'H','i' then drain
    applyStimulus(1'b1, A_TXDATA, 32'h1234_5648, 1'b0);
    checkOutput("mmio_no_ram_we", 32'(ram_we), 32'h0);
    applyStimulus(1'b1, A_TXDATA, 32'h0000_0069, 1'b0);
    checkOutput("first_push_visible", 32'(tx_data), 32'h48);
    applyStimulus(1'b0, A_STATUS, 32'h0, 1'b0);
    checkOutput("status_two", ReadData, 32'h0000_0002);
    checkOutput("hold_valid", 32'(tx_valid), 32'h1);
    checkOutput("hold_data", 32'(tx_data), 32'h48);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("drain_H", 32'(tx_data), 32'h48);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("drain_i", 32'(tx_data), 32'h69);
    applyStimulus(1'b0, A_STATUS, 32'h0, 1'b0);
    checkOutput("drained_valid", 32'(tx_valid), 32'h0);
    checkOutput("drained_status", ReadData, 32'h0000_2000);

    // 3. Overflow on the ninth push, then clear it
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, A_TXDATA, 32'(8'h10 + i), 1'b0);
    applyStimulus(1'b0, A_STATUS, 32'h0, 1'b0);
    checkOutput("full_overflow_status", ReadData, 32'h0000_C008);
    checkOutput("full_head", 32'(tx_data), 32'h10);
    applyStimulus(1'b1, A_CLROVF, 32'h0000_0123, 1'b0);
    applyStimulus(1'b0, A_STATUS, 32'h0, 1'b0);
    checkOutput("clrovf_status", ReadData, 32'h0000_4008);

    // 4. Push and pop on a full FIFO in the same cycle
    applyStimulus(1'b1, A_TXDATA, 32'h0000_00AA, 1'b1);
    applyStimulus(1'b0, A_STATUS, 32'h0, 1'b0);
    checkOutput("push_pop_full_status", ReadData, 32'h0000_4008);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("drain_valid", 32'(tx_valid), 32'h1);
      checkOutput("drain_order", 32'(tx_data), (i < 7) ? 32'(8'h11 + i) : 32'h0000_00AA);
    end
    applyStimulus(1'b0, A_STATUS, 32'h0, 1'b0);
    checkOutput("drain_done_status", ReadData, 32'h0000_2000);

    // 5. TOHOST: first write wins, cycle counter freezes
    applyStimulus(1'b0, A_CYC_HI, 32'h0, 1'b0);
    checkOutput("cyc_hi", ReadData, model_cycle[63:32]);
    applyStimulus(1'b0, A_CYC_LO, 32'h0, 1'b0);
    checkOutput("cyc_lo_running", ReadData, model_cycle[31:0]);
    applyStimulus(1'b1, A_TOHOST, 32'h0000_0001, 1'b0);
    applyStimulus(1'b1, A_TOHOST, 32'h0000_0005, 1'b0);
    checkOutput("done_set", 32'(done), 32'h1);
    applyStimulus(1'b0, A_TOHOST, 32'h0, 1'b0);
    checkOutput("exit_code_first", exit_code, 32'h0000_0001);
    checkOutput("tohost_read", ReadData, 32'h0000_0001);
    applyStimulus(1'b0, A_CYC_LO, 32'h0, 1'b0);
    checkOutput("cyc_lo_frozen_a", ReadData, model_cycle[31:0]);
    applyStimulus(1'b0, A_CYC_LO, 32'h0, 1'b0);
    checkOutput("cyc_lo_frozen_b", ReadData, model_cycle[31:0]);

    // 6. Asynchronous reset with bytes queued
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, A_TXDATA, 32'(8'h31 + i), 1'b0);
    applyStimulus(1'b0, A_STATUS, 32'h0, 1'b0);
    checkOutput("queued_status", ReadData, 32'h0000_0003);
    checkOutput("queued_head", 32'(tx_data), 32'h31);
    reset = 1'b1;
    #1;
    checkOutput("async_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("async_status", ReadData, 32'h0000_2000);
    checkOutput("async_done", 32'(done), 32'h0);
    checkOutput("async_exit_code", exit_code, 32'h0);
    DataAdr = A_CYC_LO;
    #1;
    checkOutput("async_cyc_lo", ReadData, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, A_CYC_LO, 32'h0, 1'b0);
    checkOutput("cyc_lo_after_release", ReadData, model_cycle[31:0]);
    checkOutput("post_reset_valid", 32'(tx_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
